// File: rtl/gpio_led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_led_fader
//  Purpose  : Fabric-side consumer of the MSS GPIO_x_M2F vector. Synchronises
//             the GPIO levels into the fabric clock domain, counts changes of
//             the synchronised vector and drives one soft-fading PWM LED per
//             channel. Each channel ramps its duty one step per prescaler tick
//             toward its GPIO level, so LEDs fade on/off instead of switching.
//  Ports    : FAB_CCC_GL0      - fabric clock, rising edge
//             POWER_ON_RESET_N - asynchronous active-low reset
//             GPIO_M2F[NCH]    - MSS GPIO levels, asynchronous to the clock
//             ENABLE           - fade/PWM enable, synchronous
//             LED_OUT[NCH]     - registered PWM LED drive
//             DUTY_BUSY[NCH]   - channel duty still moving toward its endpoint
//             CHG_PULSE        - one-cycle pulse on synchronised vector change
//             CHG_COUNT[16]    - saturating count of vector changes
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_led_fader #(
    parameter int NCH         = 8,
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 1024,   // clocks per duty step, >= 2
    parameter int SYNC_STAGES = 2       // synchroniser depth, >= 2
) (
    input  logic             FAB_CCC_GL0,
    input  logic             POWER_ON_RESET_N,
    input  logic [NCH-1:0]   GPIO_M2F,
    input  logic             ENABLE,
    output logic [NCH-1:0]   LED_OUT,
    output logic [NCH-1:0]   DUTY_BUSY,
    output logic             CHG_PULSE,
    output logic [15:0]      CHG_COUNT
);

    localparam logic [PWM_BITS-1:0] c_DUTY_MAX   = '1;
    localparam logic [15:0]         c_COUNT_MAX  = 16'hFFFF;
    localparam int                  c_PRESC_W    = $clog2(RAMP_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(RAMP_DIV - 1);

    logic [NCH-1:0]       r_sync [SYNC_STAGES];
    logic [NCH-1:0]       r_gprev;
    logic                 r_chg_pulse;
    logic [15:0]          r_chg_count;
    logic [PWM_BITS-1:0]  r_pc;
    logic [c_PRESC_W-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_duty [NCH];
    logic [NCH-1:0]       r_led;

    logic [NCH-1:0]       w_gs;
    logic                 w_tick;
    logic [NCH-1:0]       w_busy;

    assign w_gs = r_sync[SYNC_STAGES-1];

    // The prescaler is held at zero while disabled, but the gate on ENABLE is
    // still needed for the cycle in which ENABLE falls at the terminal count.
    assign w_tick = ENABLE && (r_presc == c_PRESC_LAST);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= GPIO_M2F;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Change detect and saturating change counter (independent of ENABLE).
    // Any number of bits flipping together is a single event.
    // ------------------------------------------------------------------
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            r_gprev     <= '0;
            r_chg_pulse <= 1'b0;
            r_chg_count <= '0;
        end else begin
            r_gprev     <= w_gs;
            r_chg_pulse <= (w_gs != r_gprev);
            if (r_chg_pulse && (r_chg_count != c_COUNT_MAX)) begin
                r_chg_count <= r_chg_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Free-running PWM counter and ramp prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            r_pc    <= '0;
            r_presc <= '0;
        end else begin
            r_pc <= r_pc + 1'b1;
            if (!ENABLE || (r_presc == c_PRESC_LAST)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel duty ramp and PWM output. Duty saturates at 0 and MAX;
    // a target reversal simply changes the step direction at the next tick.
    // Duty at MAX drives a solid 1 since (duty > pc) would leave one gap.
    // ------------------------------------------------------------------
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            for (int i = 0; i < NCH; i++) begin
                r_duty[i] <= '0;
            end
            r_led <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_tick) begin
                    if (w_gs[i] && (r_duty[i] != c_DUTY_MAX)) begin
                        r_duty[i] <= r_duty[i] + 1'b1;
                    end else if (!w_gs[i] && (r_duty[i] != '0)) begin
                        r_duty[i] <= r_duty[i] - 1'b1;
                    end
                end

                if (!ENABLE) begin
                    r_led[i] <= 1'b0;
                end else if (r_duty[i] == c_DUTY_MAX) begin
                    r_led[i] <= 1'b1;
                end else begin
                    r_led[i] <= (r_duty[i] > r_pc);
                end
            end
        end
    end

    // Busy while the duty has not reached the endpoint selected by its level.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NCH; i++) begin
            w_busy[i] = w_gs[i] ? (r_duty[i] != c_DUTY_MAX) : (r_duty[i] != '0);
        end
    end

    assign LED_OUT   = r_led;
    assign DUTY_BUSY = w_busy;
    assign CHG_PULSE = r_chg_pulse;
    assign CHG_COUNT = r_chg_count;

endmodule
`default_nettype wire
